// File: rtl/twiddle_pkg.sv
// Shared twiddle constants for the FFT/IFFT twiddle multipliers: Q1.10 cos/sin tables and sample types.
// The forward multiplier uses -TW_SIN; the IFFT conjugate multiplier uses TW_SIN directly.
package twiddle_pkg;

    localparam int TW_W     = 12;
    localparam int TW_FRAC  = 10;
    localparam int TW_N     = 64;
    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_W-1:0] c;
        logic signed [TW_W-1:0] s;
    } tw_t;

    // round(1024*cos(2*pi*k/64))
    localparam int TW_COS [TW_N] = '{
         1024,  1019,  1004,   980,   946,   903,   851,   792,
          724,   650,   569,   483,   392,   297,   200,   100,
            0,  -100,  -200,  -297,  -392,  -483,  -569,  -650,
         -724,  -792,  -851,  -903,  -946,  -980, -1004, -1019,
        -1024, -1019, -1004,  -980,  -946,  -903,  -851,  -792,
         -724,  -650,  -569,  -483,  -392,  -297,  -200,  -100,
            0,   100,   200,   297,   392,   483,   569,   650,
          724,   792,   851,   903,   946,   980,  1004,  1019
    };

    // round(1024*sin(2*pi*k/64))
    localparam int TW_SIN [TW_N] = '{
            0,   100,   200,   297,   392,   483,   569,   650,
          724,   792,   851,   903,   946,   980,  1004,  1019,
         1024,  1019,  1004,   980,   946,   903,   851,   792,
          724,   650,   569,   483,   392,   297,   200,   100,
            0,  -100,  -200,  -297,  -392,  -483,  -569,  -650,
         -724,  -792,  -851,  -903,  -946,  -980, -1004, -1019,
        -1024, -1019, -1004,  -980,  -946,  -903,  -851,  -792,
         -724,  -650,  -569,  -483,  -392,  -297,  -200,  -100
    };

    function automatic tw_t tw_lookup(input logic [5:0] k);
        tw_t t;
        t.c = TW_W'(TW_COS[k]);
        t.s = TW_W'(TW_SIN[k]);
        return t;
    endfunction

endpackage

// File: rtl/twiddle_idx_ctr.sv
// Per-beat twiddle index counter with frame alignment check.
// frame_err pulses the cycle after a beat whose in_last disagrees with the index reaching N_PT-1.
module twiddle_idx_ctr
    import twiddle_pkg::*;
#(
    parameter int N_PT  = TW_N,
    parameter int CNT_W = $clog2(N_PT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_last,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_frame_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PT - 1);

    logic [CNT_W-1:0] r_idx;
    logic             r_frame_err;
    logic             w_at_end;

    assign w_at_end = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= i_accept && (i_last != w_at_end);
            if (i_accept) begin
                r_idx <= (i_last || w_at_end) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign o_idx       = r_idx;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/twiddle_conj_mult_pipe.sv
// IFFT twiddle multiplier: rotates each sample by conj(W^k) through a 3-stage stalling pipeline.
// Define TWIDDLE_SAT_EN to clamp the scaled result instead of wrapping.
module twiddle_conj_mult_pipe
    import twiddle_pkg::*;
#(
    parameter int BW      = 16,
    parameter int N_pt    = 64,
    parameter int cnt_num = $clog2(N_pt)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [BW-1:0] in_Real,
    input  logic signed [BW-1:0] in_Imag,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [BW-1:0] out_Real,
    output logic signed [BW-1:0] out_Imag,
    output logic                 out_last,
    output logic [cnt_num-1:0]   out_idx,
    output logic                 frame_err
);

    localparam int PW = BW + TW_W;
    localparam int SW = BW + TW_W + 1;

`ifdef TWIDDLE_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (BW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    function automatic logic signed [BW-1:0] scale(input logic signed [SW-1:0] sum);
`ifdef TWIDDLE_SAT_EN
        logic signed [SW-1:0] sh;
        sh = sum >>> TW_FRAC;
        if (sh > SAT_MAX) return SAT_MAX[BW-1:0];
        if (sh < SAT_MIN) return SAT_MIN[BW-1:0];
        return sh[BW-1:0];
`else
        return {sum[SW-1], sum[TW_FRAC+BW-2:TW_FRAC]};
`endif
    endfunction

    logic               w_adv;
    logic               w_accept;
    logic [cnt_num-1:0] w_idx;
    logic               w_frame_err;
    tw_t                w_tw;

    logic                 r_v1, r_last1;
    logic [cnt_num-1:0]   r_idx1;
    logic signed [BW-1:0] r_ar1, r_ai1;
    logic signed [TW_W-1:0] r_c1, r_s1;

    logic                 r_v2, r_last2;
    logic [cnt_num-1:0]   r_idx2;
    logic signed [PW-1:0] r_p_rc, r_p_is, r_p_rs, r_p_ic;

    logic                 r_v3, r_last3;
    logic [cnt_num-1:0]   r_idx3;
    logic signed [BW-1:0] r_re3, r_im3;

    logic signed [SW-1:0] w_re, w_im;

    // All stages advance together; a stalled output freezes the whole pipe.
    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;

    twiddle_idx_ctr #(
        .N_PT  (N_pt),
        .CNT_W (cnt_num)
    ) u_idx_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_accept),
        .i_last      (in_last),
        .o_idx       (w_idx),
        .o_frame_err (w_frame_err)
    );

    assign w_tw = tw_lookup(w_idx);

    // conj twiddle: (ar + j ai)(c + j s)
    assign w_re = SW'(r_p_rc) - SW'(r_p_is);
    assign w_im = SW'(r_p_rs) + SW'(r_p_ic);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_idx1  <= '0;
            r_ar1   <= '0;
            r_ai1   <= '0;
            r_c1    <= '0;
            r_s1    <= '0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_idx2  <= '0;
            r_p_rc  <= '0;
            r_p_is  <= '0;
            r_p_rs  <= '0;
            r_p_ic  <= '0;
            r_v3    <= 1'b0;
            r_last3 <= 1'b0;
            r_idx3  <= '0;
            r_re3   <= '0;
            r_im3   <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_last1 <= in_valid && in_last;
            if (in_valid) begin
                r_idx1 <= w_idx;
                r_ar1  <= in_Real;
                r_ai1  <= in_Imag;
                r_c1   <= w_tw.c;
                r_s1   <= w_tw.s;
            end

            r_v2    <= r_v1;
            r_last2 <= r_v1 && r_last1;
            if (r_v1) begin
                r_idx2 <= r_idx1;
                r_p_rc <= PW'(r_ar1) * PW'(r_c1);
                r_p_is <= PW'(r_ai1) * PW'(r_s1);
                r_p_rs <= PW'(r_ar1) * PW'(r_s1);
                r_p_ic <= PW'(r_ai1) * PW'(r_c1);
            end

            r_v3    <= r_v2;
            r_last3 <= r_v2 && r_last2;
            if (r_v2) begin
                r_idx3 <= r_idx2;
                r_re3  <= scale(w_re);
                r_im3  <= scale(w_im);
            end
        end
    end

    assign out_valid = r_v3;
    assign out_last  = r_last3;
    assign out_idx   = r_idx3;
    assign out_Real  = r_re3;
    assign out_Imag  = r_im3;
    assign frame_err = w_frame_err;

endmodule

// File: tb/tb_twiddle_conj_mult_pipe.sv
// Scoreboard bench for twiddle_conj_mult_pipe: directed vectors queued on accept, checked by a monitor.
module tb_twiddle_conj_mult_pipe;
    import twiddle_pkg::*;

    localparam int BW = 16;

`ifdef TWIDDLE_SAT_EN
    localparam int OVF_IM = 32767;
`else
    localparam int OVF_IM = 13566;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BW-1:0] in_Real = '0;
    logic signed [BW-1:0] in_Imag = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [BW-1:0] out_Real;
    logic signed [BW-1:0] out_Imag;
    logic                 out_last;
    logic [5:0]           out_idx;
    logic                 frame_err;

    always #5 clk = ~clk;

    twiddle_conj_mult_pipe #(.BW(BW), .N_pt(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_Real   (in_Real),
        .in_Imag   (in_Imag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Real  (out_Real),
        .out_Imag  (out_Imag),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .frame_err (frame_err)
    );

    typedef struct {
        cplx_t      d;
        logic [5:0] idx;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pend     = 1'b0;
    logic pend_err = 1'b0;
    logic toggle   = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scl(input longint v);
        longint h;
        logic [15:0] r;
        h = v >>> 10;
`ifdef TWIDDLE_SAT_EN
        if (h > 32767) return 32767;
        if (h < -32768) return -32768;
        r = h[15:0];
`else
        r = {v[28], h[14:0]};
`endif
        return int'($signed(r));
    endfunction

    function automatic void model(input int ar, input int ai, input int k, output int ore, output int oim);
        real ang;
        int c, s;
        ang = 2.0 * 3.14159265358979 * real'(k) / 64.0;
        c = int'(1024.0 * $cos(ang));
        s = int'(1024.0 * $sin(ang));
        ore = scl(longint'(ar) * c - longint'(ai) * s);
        oim = scl(longint'(ar) * s + longint'(ai) * c);
    endfunction

    // One clock: frame_err must match the beat accepted at this edge (or be low).
    task automatic tick();
        @(posedge clk);
        #1;
        chk("frame_err", frame_err, pend ? pend_err : 1'b0);
        pend = 1'b0;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic send(input int ar, input int ai, input logic last, input logic [5:0] eidx,
                        input logic eerr, input int ere, input int eim);
        exp_t e;
        int n;
        in_valid = 1'b1;
        in_Real  = 16'(ar);
        in_Imag  = 16'(ai);
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.d.re = 16'(ere);
                e.d.im = 16'(eim);
                e.idx  = eidx;
                e.last = last;
                q.push_back(e);
                pend     = 1'b1;
                pend_err = eerr;
                tick();
                break;
            end
            tick();
            n++;
            if (n > 200) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_m(input int ar, input int ai, input logic last, input int k, input logic eerr);
        int re, im;
        model(ar, ai, k, re, im);
        send(ar, ai, last, 6'(k), eerr, re, im);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Monitor: pops on every output handshake and checks holds under stall.
    logic                 stall = 1'b0;
    logic signed [BW-1:0] h_re, h_im;
    logic [5:0]           h_idx;
    logic                 h_last;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_Real", out_Real, h_re);
                    chk("hold_Imag", out_Imag, h_im);
                    chk("hold_idx", out_idx, h_idx);
                    chk("hold_last", out_last, h_last);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("out_Real", out_Real, e.d.re);
                        chk("out_Imag", out_Imag, e.d.im);
                        chk("out_idx", out_idx, e.idx);
                        chk("out_last", out_last, e.last);
                    end
                end
                stall  = out_valid && !out_ready;
                h_re   = out_Real;
                h_im   = out_Imag;
                h_idx  = out_idx;
                h_last = out_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_out_Real", out_Real, 0);
        chk("rst_out_Imag", out_Imag, 0);
        chk("rst_out_idx", out_idx, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Frame A: impulse at idx 0 with latency probe, early in_last at idx 16
        send(1000, 0, 1'b0, 6'd0, 1'b0, 1000, 0);
        chk("lat_cycle1", out_valid, 1'b0);
        tick();
        chk("lat_cycle2", out_valid, 1'b0);
        tick();
        chk("lat_cycle3", out_valid, 1'b1);
        for (int k = 1; k < 16; k++) send_m(k * 37 - 300, 200 - k * 11, 1'b0, k, 1'b0);
        send(1000, 0, 1'b1, 6'd16, 1'b1, 0, 1000);

        // Frame B: aligned, directed points at 8, 16, 32
        for (int k = 0; k < 64; k++) begin
            if (k == 8)       send(1024, 0, 1'b0, 6'd8, 1'b0, 724, 724);
            else if (k == 16) send(0, 1000, 1'b0, 6'd16, 1'b0, -1000, 0);
            else if (k == 32) send(1000, 500, 1'b0, 6'd32, 1'b0, -1000, -500);
            else              send_m(k * 53 - 1500, 900 - k * 29, k == 63, k, 1'b0);
        end

        // Frame C: overflow at idx 8, in_last on beat 10
        for (int k = 0; k < 11; k++) begin
            if (k == 8) send(32767, 32767, 1'b0, 6'd8, 1'b0, 0, OVF_IM);
            else        send_m(k * 211 - 700, k * 13, k == 10, k, k == 10);
        end

        // Frame D: 64 beats under 1010 backpressure
        toggle = 1'b1;
        for (int k = 0; k < 64; k++) send_m(k * 97 - 3000, 2500 - k * 61, k == 63, k, 1'b0);
        toggle = 1'b0;
        out_ready = 1'b1;
        drain();

        // Frame E: 65 beats without in_last
        for (int k = 0; k < 65; k++) send_m(4000 - k * 120, k * 45 - 1200, 1'b0, k % 64, k == 63);

        // Reset mid-frame
        for (int k = 1; k < 6; k++) send_m(k * 300, -k * 150, 1'b0, k, 1'b0);
        rst = 1'b1;
        pend = 1'b0;
        #2;
        q.delete();
        chk("midrst_out_valid", out_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid_after", out_valid, 1'b0);
        send_m(1234, -567, 1'b0, 0, 1'b0);
        send_m(-2222, 3333, 1'b0, 1, 1'b0);
        drain();
        tick();
        chk("final_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
